// File: rtl/cart_mem_arbiter_if.sv
// Purpose: bundles the cart strobe bus, host loader handshake, memory port and error flags.
// Latency: none; this is wiring only.
// Backpressure: carried by host_req/host_gnt and mem_req/mem_ack; cart strobes cannot be stalled.
interface cart_mem_arbiter_if;
  logic        cart_rd;
  logic        cart_wr;
  logic [25:0] cart_addr;
  logic [1:0]  cart_data_width;
  logic [15:0] cart_wr_data;
  logic [15:0] cart_rd_data;
  logic        cart_rd_valid;
  logic        host_req;
  logic        host_we;
  logic [25:0] host_addr;
  logic [1:0]  host_width;
  logic [15:0] host_wr_data;
  logic        host_gnt;
  logic [15:0] host_rd_data;
  logic        host_rd_valid;
  logic        mem_req;
  logic        mem_we;
  logic [25:0] mem_addr;
  logic [1:0]  mem_be;
  logic [15:0] mem_wr_data;
  logic        mem_ack;
  logic [15:0] mem_rd_data;
  logic        clear_err;
  logic        err_timeout;
  logic        err_overrun;

  // Arbiter side of the bundle.
  modport slave (
    input  cart_rd, cart_wr, cart_addr, cart_data_width, cart_wr_data,
    output cart_rd_data, cart_rd_valid,
    input  host_req, host_we, host_addr, host_width, host_wr_data,
    output host_gnt, host_rd_data, host_rd_valid,
    output mem_req, mem_we, mem_addr, mem_be, mem_wr_data,
    input  mem_ack, mem_rd_data,
    input  clear_err,
    output err_timeout, err_overrun
  );

  // Requester / memory-controller side of the bundle.
  modport master (
    output cart_rd, cart_wr, cart_addr, cart_data_width, cart_wr_data,
    input  cart_rd_data, cart_rd_valid,
    output host_req, host_we, host_addr, host_width, host_wr_data,
    input  host_gnt, host_rd_data, host_rd_valid,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wr_data,
    output mem_ack, mem_rd_data,
    output clear_err,
    input  err_timeout, err_overrun
  );
endinterface

// File: rtl/cart_mem_arbiter.sv
// Purpose: shares one memory port between the cart bus (priority, one-cycle strobes) and a host loader.
// Latency: strobe at t -> mem_req at t+1; mem_ack at a -> rd_valid at a+1; next mem_req no earlier than a+2.
// Backpressure: host waits on host_gnt; cart strobes are never stalled, extras are dropped and flagged.
module cart_mem_arbiter #(
  parameter int          TIMEOUT_CYCLES = 64,
  parameter logic [15:0] ERR_RD_DATA    = 16'hFFFF
) (
  input logic              clk,
  input logic              rst,
  cart_mem_arbiter_if.slave bus
);

  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, CART, HOST} state_t;

  typedef struct packed {
    logic        we;
    logic [25:0] addr;
    logic [1:0]  width;
    logic [15:0] wr_data;
  } req_t;

  state_t         state;
  logic           cart_pend;   // set from capture until the cart transaction completes or aborts
  req_t           cart_req;
  logic [WDW-1:0] wdog;
  logic           cur_byte;    // active transaction uses the 8-bit lane

  logic        strobe;
  logic        accept;
  logic        start_cart;
  req_t        new_req;
  req_t        host_fields;
  req_t        launch;
  logic        launch_byte;
  logic [15:0] rd_val;

  // Capture decode, choice of fields to launch, and lane handling of returning read data.
  always_comb begin
    strobe      = bus.cart_rd | bus.cart_wr;
    accept      = strobe & ~cart_pend;
    start_cart  = cart_pend | strobe;
    // Write wins when both strobes fire in one cycle.
    new_req     = '{we: bus.cart_wr, addr: bus.cart_addr,
                    width: bus.cart_data_width, wr_data: bus.cart_wr_data};
    host_fields = '{we: bus.host_we, addr: bus.host_addr,
                    width: bus.host_width, wr_data: bus.host_wr_data};
    launch      = host_fields;
    if (start_cart) launch = accept ? new_req : cart_req;
    // Only 2'b01 selects the byte lane; every other width runs as 16-bit.
    launch_byte = (launch.width == 2'b01);
    rd_val      = cur_byte ? {8'h00, bus.mem_rd_data[7:0]} : bus.mem_rd_data;
  end

  // Host is granted in the same cycle it is seen, only from IDLE with no cart work waiting.
  assign bus.host_gnt = ~rst & (state == IDLE) & ~start_cart & bus.host_req;

  // Arbitration FSM, cart capture, watchdog and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      cart_pend         <= 1'b0;
      cart_req          <= '0;
      wdog              <= '0;
      cur_byte          <= 1'b0;
      bus.mem_req       <= 1'b0;
      bus.mem_we        <= 1'b0;
      bus.mem_addr      <= '0;
      bus.mem_be        <= '0;
      bus.mem_wr_data   <= '0;
      bus.cart_rd_data  <= '0;
      bus.cart_rd_valid <= 1'b0;
      bus.host_rd_data  <= '0;
      bus.host_rd_valid <= 1'b0;
      bus.err_timeout   <= 1'b0;
      bus.err_overrun   <= 1'b0;
    end else begin
      bus.cart_rd_valid <= 1'b0;
      bus.host_rd_valid <= 1'b0;

      if (accept) begin
        cart_pend <= 1'b1;
        cart_req  <= new_req;
      end

      // A set event in the same cycle overrides clear_err.
      if (strobe && cart_pend) bus.err_overrun <= 1'b1;
      else if (bus.clear_err)  bus.err_overrun <= 1'b0;
      if (bus.clear_err)       bus.err_timeout <= 1'b0;

      case (state)
        IDLE: begin
          if (start_cart || bus.host_req) begin
            state           <= start_cart ? CART : HOST;
            wdog            <= '0;
            cur_byte        <= launch_byte;
            bus.mem_req     <= 1'b1;
            bus.mem_we      <= launch.we;
            bus.mem_addr    <= launch.addr;
            bus.mem_be      <= launch_byte ? 2'b01 : 2'b11;
            bus.mem_wr_data <= launch_byte ? {8'h00, launch.wr_data[7:0]} : launch.wr_data;
          end
        end
        default: begin
          if (bus.mem_ack || wdog == WD_LAST) begin
            state       <= IDLE;
            bus.mem_req <= 1'b0;
            if (state == CART) cart_pend <= 1'b0;
            // An ack in the abort cycle is a normal completion.
            if (!bus.mem_ack) bus.err_timeout <= 1'b1;
            if (!bus.mem_we) begin
              if (state == CART) begin
                bus.cart_rd_valid <= 1'b1;
                bus.cart_rd_data  <= bus.mem_ack ? rd_val : ERR_RD_DATA;
              end else begin
                bus.host_rd_valid <= 1'b1;
                bus.host_rd_data  <= bus.mem_ack ? rd_val : ERR_RD_DATA;
              end
            end
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cart_mem_arbiter.sv
// Purpose: directed self-checking bench for cart_mem_arbiter.
// Latency: inputs change 1 time unit after a rising edge and outputs are checked in that same window.
// Backpressure: the bench plays the memory controller and chooses when to return mem_ack.
module tb_cart_mem_arbiter;
  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;

  cart_mem_arbiter_if bus ();

  cart_mem_arbiter #(.TIMEOUT_CYCLES(64), .ERR_RD_DATA(16'hFFFF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
    $fatal(1, "time limit");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic ack(input logic [15:0] d);
    bus.mem_ack     = 1'b1;
    bus.mem_rd_data = d;
    step();
    bus.mem_ack     = 1'b0;
    bus.mem_rd_data = 16'h0000;
  endtask

  task automatic cart(input logic wr, input logic [25:0] a, input logic [1:0] w, input logic [15:0] d);
    bus.cart_rd         = ~wr;
    bus.cart_wr         = wr;
    bus.cart_addr       = a;
    bus.cart_data_width = w;
    bus.cart_wr_data    = d;
  endtask

  task automatic cart_idle();
    bus.cart_rd = 1'b0;
    bus.cart_wr = 1'b0;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus.cart_rd = 0; bus.cart_wr = 0; bus.cart_addr = '0; bus.cart_data_width = 2'b10;
    bus.cart_wr_data = '0; bus.host_req = 0; bus.host_we = 0; bus.host_addr = '0;
    bus.host_width = 2'b10; bus.host_wr_data = '0; bus.mem_ack = 0; bus.mem_rd_data = '0;
    bus.clear_err = 0;
    step(); step();

    // Reset state
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_mem_be", 32'(bus.mem_be), 32'd0);
    chk("rst_cart_valid", 32'(bus.cart_rd_valid), 32'd0);
    chk("rst_cart_data", 32'(bus.cart_rd_data), 32'd0);
    chk("rst_host_gnt", 32'(bus.host_gnt), 32'd0);
    chk("rst_host_data", 32'(bus.host_rd_data), 32'd0);
    chk("rst_err_to", 32'(bus.err_timeout), 32'd0);
    chk("rst_err_ov", 32'(bus.err_overrun), 32'd0);
    rst = 1'b0;
    step();

    // Cart 16-bit read, ack three cycles after mem_req
    cart(1'b0, 26'h0000100, 2'b10, 16'h0000);
    step(); cart_idle();
    chk("t1_mem_req", 32'(bus.mem_req), 32'd1);
    chk("t1_mem_we", 32'(bus.mem_we), 32'd0);
    chk("t1_mem_addr", 32'(bus.mem_addr), 32'h0000100);
    chk("t1_mem_be", 32'(bus.mem_be), 32'h3);
    step(); step();
    chk("t1_req_held", 32'(bus.mem_req), 32'd1);
    chk("t1_no_early_valid", 32'(bus.cart_rd_valid), 32'd0);
    ack(16'hBEEF);
    chk("t1_req_drop", 32'(bus.mem_req), 32'd0);
    chk("t1_valid", 32'(bus.cart_rd_valid), 32'd1);
    chk("t1_data", 32'(bus.cart_rd_data), 32'hBEEF);
    step();
    chk("t1_valid_pulse", 32'(bus.cart_rd_valid), 32'd0);

    // Cart 8-bit write to backup space
    cart(1'b1, 26'h2000005, 2'b01, 16'h00A5);
    step(); cart_idle();
    chk("t2_mem_req", 32'(bus.mem_req), 32'd1);
    chk("t2_mem_we", 32'(bus.mem_we), 32'd1);
    chk("t2_mem_addr", 32'(bus.mem_addr), 32'h2000005);
    chk("t2_mem_be", 32'(bus.mem_be), 32'h1);
    chk("t2_wr_data", 32'(bus.mem_wr_data[7:0]), 32'hA5);
    ack(16'h1234);
    chk("t2_no_valid", 32'(bus.cart_rd_valid), 32'd0);
    chk("t2_req_drop", 32'(bus.mem_req), 32'd0);
    step();

    // Host read in flight, cart strobe waits for it
    bus.host_req = 1; bus.host_we = 0; bus.host_addr = 26'h0000040; bus.host_width = 2'b10;
    #1;
    chk("t3_gnt", 32'(bus.host_gnt), 32'd1);
    step(); bus.host_req = 0;
    chk("t3_host_req", 32'(bus.mem_req), 32'd1);
    chk("t3_host_addr", 32'(bus.mem_addr), 32'h0000040);
    cart(1'b0, 26'h0000200, 2'b10, 16'h0000);
    step(); cart_idle();
    chk("t3_no_preempt", 32'(bus.mem_addr), 32'h0000040);
    step(); step(); step();
    ack(16'h1234);
    chk("t3_host_valid", 32'(bus.host_rd_valid), 32'd1);
    chk("t3_host_data", 32'(bus.host_rd_data), 32'h1234);
    chk("t3_cart_valid0", 32'(bus.cart_rd_valid), 32'd0);
    chk("t3_idle_gap", 32'(bus.mem_req), 32'd0);
    step();
    chk("t3_cart_req", 32'(bus.mem_req), 32'd1);
    chk("t3_cart_addr", 32'(bus.mem_addr), 32'h0000200);
    ack(16'h5A5A);
    chk("t3_cart_data", 32'(bus.cart_rd_data), 32'h5A5A);
    chk("t3_cart_valid", 32'(bus.cart_rd_valid), 32'd1);
    step();

    // Same-cycle cart read and host write: cart first
    cart(1'b0, 26'h0000300, 2'b10, 16'h0000);
    bus.host_req = 1; bus.host_we = 1; bus.host_addr = 26'h0000080;
    bus.host_width = 2'b01; bus.host_wr_data = 16'h12C3;
    #1;
    chk("t4_gnt_lost", 32'(bus.host_gnt), 32'd0);
    step(); cart_idle();
    chk("t4_cart_addr", 32'(bus.mem_addr), 32'h0000300);
    chk("t4_gnt_busy", 32'(bus.host_gnt), 32'd0);
    ack(16'h7E81);
    chk("t4_cart_data", 32'(bus.cart_rd_data), 32'h7E81);
    #1;
    chk("t4_gnt_after", 32'(bus.host_gnt), 32'd1);
    step(); bus.host_req = 0;
    chk("t4_host_we", 32'(bus.mem_we), 32'd1);
    chk("t4_host_addr", 32'(bus.mem_addr), 32'h0000080);
    chk("t4_host_be", 32'(bus.mem_be), 32'h1);
    chk("t4_host_wdata", 32'(bus.mem_wr_data), 32'h00C3);
    ack(16'h0000);
    chk("t4_no_host_valid", 32'(bus.host_rd_valid), 32'd0);
    step();

    // Host 8-bit read zero-extends; width 2'b00 runs as 16-bit
    bus.host_req = 1; bus.host_we = 0; bus.host_addr = 26'h0000090; bus.host_width = 2'b01;
    step(); bus.host_req = 0;
    chk("t5_be8", 32'(bus.mem_be), 32'h1);
    ack(16'hABCD);
    chk("t5_zext", 32'(bus.host_rd_data), 32'h00CD);
    step();
    cart(1'b0, 26'h00000A0, 2'b00, 16'h0000);
    step(); cart_idle();
    chk("t5_w00_be", 32'(bus.mem_be), 32'h3);
    ack(16'hABCD);
    chk("t5_w00_data", 32'(bus.cart_rd_data), 32'hABCD);
    step();

    // Watchdog abort on a cart read
    cart(1'b0, 26'h0000400, 2'b10, 16'h0000);
    step(); cart_idle();
    for (int i = 0; i < 63; i++) step();
    chk("t6_req_64th", 32'(bus.mem_req), 32'd1);
    chk("t6_no_err_yet", 32'(bus.err_timeout), 32'd0);
    step();
    chk("t6_req_drop", 32'(bus.mem_req), 32'd0);
    chk("t6_valid", 32'(bus.cart_rd_valid), 32'd1);
    chk("t6_err_data", 32'(bus.cart_rd_data), 32'hFFFF);
    chk("t6_err_to", 32'(bus.err_timeout), 32'd1);
    bus.clear_err = 1;
    step(); bus.clear_err = 0;
    chk("t6_err_clr", 32'(bus.err_timeout), 32'd0);

    // Overrun: second strobe dropped, one transaction only
    cart(1'b0, 26'h0000500, 2'b10, 16'h0000);
    step();
    cart(1'b1, 26'h0000600, 2'b10, 16'h9999);
    step(); cart_idle();
    chk("t7_err_ov", 32'(bus.err_overrun), 32'd1);
    chk("t7_addr_kept", 32'(bus.mem_addr), 32'h0000500);
    ack(16'h1111);
    chk("t7_data", 32'(bus.cart_rd_data), 32'h1111);
    step();
    chk("t7_one_txn_a", 32'(bus.mem_req), 32'd0);
    step();
    chk("t7_one_txn_b", 32'(bus.mem_req), 32'd0);

    // Set beats clear in the same cycle
    cart(1'b0, 26'h0000700, 2'b10, 16'h0000);
    step();
    cart(1'b1, 26'h0000704, 2'b10, 16'h0000);
    bus.clear_err = 1;
    step(); cart_idle();
    chk("t8_set_wins", 32'(bus.err_overrun), 32'd1);
    step(); bus.clear_err = 0;
    chk("t8_cleared", 32'(bus.err_overrun), 32'd0);
    ack(16'h2222);
    step();

    // Reset mid-transaction, late ack ignored
    cart(1'b0, 26'h0000800, 2'b10, 16'h0000);
    step(); cart_idle();
    chk("t9_req", 32'(bus.mem_req), 32'd1);
    rst = 1;
    step(); rst = 0;
    chk("t9_rst_req", 32'(bus.mem_req), 32'd0);
    chk("t9_rst_addr", 32'(bus.mem_addr), 32'd0);
    chk("t9_rst_cdata", 32'(bus.cart_rd_data), 32'd0);
    ack(16'hDEAD);
    chk("t9_late_valid", 32'(bus.cart_rd_valid), 32'd0);
    chk("t9_late_req", 32'(bus.mem_req), 32'd0);
    step();
    chk("t9_no_relaunch", 32'(bus.mem_req), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/cart_mem_arbiter.md
Name: cart_mem_arbiter

Overview:
- Shares one backing-memory port between two requesters: the GBA cartridge bus, which has priority and issues one-cycle strobes, and a host loader (ROM upload/readback) using a req/grant handshake.
- Sits between the cart bus front-end (cart_mux.cart modport side) and the memory controller.
- Captures each cart strobe, sequences exactly one memory transaction per request and returns read data with a one-cycle valid.
- Watchdog and overrun flags guarantee forward progress and record errors.

Parameters:
TIMEOUT_CYCLES, 64, max cycles mem_req may stay high without mem_ack before abort
ERR_RD_DATA, 16'hFFFF, data returned on an aborted read

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
cart_rd  in  1  one-cycle cart read strobe
cart_wr  in  1  one-cycle cart write strobe
cart_addr  in  26  cart address; bit25=1 selects backup (8-bit) space
cart_data_width  in  2  2'b10 = 16-bit, 2'b01 = 8-bit
cart_wr_data  in  16  cart write data, valid in strobe cycle
cart_rd_data  out  16  registered read data
cart_rd_valid  out  1  one-cycle pulse, cart read complete
host_req  in  1  host request, level, held until host_gnt
host_we  in  1  1 = write
host_addr  in  26  host address
host_width  in  2  same encoding as cart_data_width
host_wr_data  in  16  host write data
host_gnt  out  1  one-cycle pulse, host request accepted
host_rd_data  out  16  registered read data
host_rd_valid  out  1  one-cycle pulse, host read complete
mem_req  out  1  level request, held until mem_ack or abort
mem_we  out  1  write enable
mem_addr  out  26  address
mem_be  out  2  byte enables
mem_wr_data  out  16  write data
mem_ack  in  1  one-cycle completion
mem_rd_data  in  16  valid with mem_ack on reads
clear_err  in  1  clears sticky error flags
err_timeout  out  1  sticky, any abort occurred
err_overrun  out  1  sticky, cart strobe dropped

Behaviour:
- Reset: state IDLE. All outputs 0, including rd_data registers and flags. Cart pending register and watchdog counter cleared. An in-flight transaction is abandoned, and a mem_ack arriving in IDLE is ignored.
- Cart capture:
  - cart_rd|cart_wr loads the pending register (addr, we, width, wr_data) in the strobe cycle.
  - Write strobe takes precedence if both are asserted; treat as write.
  - A strobe while a cart request is already pending or in flight is dropped and sets err_overrun.
- States IDLE, CART, HOST.
  - IDLE: if a cart request is pending or strobing this cycle -> CART. Else if host_req -> HOST, host_gnt=1 that cycle, host fields latched.
  - Simultaneous cart strobe and host_req: cart wins; host_gnt stays 0.
  - CART/HOST: mem_req=1 with latched fields. mem_ack -> IDLE and clear the cart pending register (CART).
- Latency:
  - Cart strobe at cycle t in IDLE -> mem_req high at t+1.
  - mem_ack at cycle a -> cart_rd_valid/host_rd_valid pulse at a+1 with data = mem_rd_data sampled at a.
  - Writes produce no valid.
  - Back-to-back: the next request may raise mem_req at a+2 at the earliest (one IDLE cycle).
- Host starvation is allowed: host is granted only in IDLE with no cart request. The current host transaction is never preempted; a cart request waits for it.
- Width/byte-lane:
  - Width 2'b10 -> mem_be=2'b11.
  - Width 2'b01 -> mem_be=2'b01; write data is taken from bits [7:0], and read data returns zero-extended from bits [7:0].
  - Width 2'b00 -> request treated as 16-bit.
- Watchdog:
  - Counter starts at 0 on entry to CART/HOST and increments each cycle mem_req is high without mem_ack.
  - When it reaches TIMEOUT_CYCLES-1: drop mem_req, go to IDLE, set err_timeout.
  - Aborted reads pulse the matching rd_valid with ERR_RD_DATA; aborted writes produce no pulse.
  - mem_ack in the abort cycle counts as a normal completion.
- Flags: err_* clear on clear_err. A set event in the same cycle wins over clear.
- mem_* outputs, including mem_req, are registered; mem_we/addr/be/wr_data are stable while mem_req=1.

Test Plan:
- Cart read 16-bit, addr 26'h0000100; mem_ack 3 cycles after mem_req with 16'hBEEF -> mem_be=2'b11, cart_rd_valid pulse one cycle after ack, cart_rd_data=16'hBEEF.
- Cart 8-bit write, addr 26'h2000005, data 16'h00A5 -> mem_we=1, mem_be=2'b01, mem_wr_data[7:0]=8'hA5, no rd_valid.
- Host read in flight (ack held off 5 cycles), cart strobe arrives -> host completes first; mem_req reasserts for the cart addr two cycles after the host ack.
- Same-cycle cart_rd and host_req in IDLE -> cart served first; host_gnt only after the cart ack.
- mem_ack never asserted, TIMEOUT_CYCLES=64, cart read -> mem_req drops after 64 cycles, cart_rd_valid with 16'hFFFF, err_timeout=1; clear_err -> 0.
- Second cart strobe while the first is pending -> err_overrun=1, exactly one memory transaction; rst asserted mid-transaction -> all outputs 0 next cycle, late mem_ack ignored.
